// File: rtl/multiword_add_sequencer.sv
// Multi-precision adder: one WIDTH-bit Kogge-Stone adder reused over WORDS cycles, LSW first.
// Optional subtract mode (a - b) is enabled by defining MULTIWORD_SUB_EN.

module kogge_stone_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned STAGES = (WIDTH > 1) ? $clog2(WIDTH) : 0;
  localparam int unsigned PTOP   = (STAGES > 0) ? STAGES - 1 : 0;

  logic [STAGES:0][WIDTH-1:0] g;
  logic [PTOP:0][WIDTH-1:0]   p;
  logic [WIDTH-1:0]           c;

  assign g[0] = a & b;
  assign p[0] = a ^ b;

  // Log-depth parallel prefix over (generate, propagate); the last stage only needs g.
  for (genvar s = 0; s < int'(STAGES); s++) begin : g_stage
    localparam int D = 1 << s;
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
      if (i >= D) begin : g_merge
        assign g[s+1][i] = g[s][i] | (p[s][i] & g[s][i-D]);
        if (s + 1 < int'(STAGES)) begin : g_prop
          assign p[s+1][i] = p[s][i] & p[s][i-D];
        end
      end else begin : g_pass
        assign g[s+1][i] = g[s][i];
        if (s + 1 < int'(STAGES)) begin : g_prop
          assign p[s+1][i] = p[s][i];
        end
      end
    end
  end

  assign c[0] = 1'b0;
  for (genvar i = 1; i < int'(WIDTH); i++) begin : g_carry
    assign c[i] = g[STAGES][i-1];
  end

  assign sum  = p[0] ^ c;
  assign cout = g[STAGES][WIDTH-1];

endmodule

module multiword_add_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
`ifdef MULTIWORD_SUB_EN
  input  logic                   sub,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] sum,
  output logic                   carry_out
);

  localparam int unsigned IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [WORDS-1:0][WIDTH-1:0] a_q, b_q, sum_q;
  logic [IDXW-1:0]             idx;
  logic                        carry;

  logic             accept_c, run_c, last_c;
  logic             sub_c;
  logic [WIDTH-1:0] raw_c;
  logic             kc_c;
  logic [WIDTH:0]   inc_c;

`ifdef MULTIWORD_SUB_EN
  assign sub_c = sub;
`else
  assign sub_c = 1'b0;
`endif

  kogge_stone_adder #(.WIDTH(WIDTH)) u_ksa (
    .a    (a_q[idx]),
    .b    (b_q[idx]),
    .sum  (raw_c),
    .cout (kc_c)
  );

  // Inter-word carry enters through an increment; kc and the increment overflow are exclusive.
  assign inc_c = {1'b0, raw_c} + (WIDTH+1)'(carry);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (in_valid)          state_n = ST_RUN;
      ST_RUN:  if (idx == LAST_IDX)   state_n = ST_DONE;
      ST_DONE: if (out_ready)         state_n = ST_IDLE;
      default:                        state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    accept_c = 1'b0;
    run_c    = 1'b0;
    last_c   = 1'b0;
    case (state)
      ST_IDLE: accept_c = in_valid;
      ST_RUN: begin
        run_c  = 1'b1;
        last_c = (idx == LAST_IDX);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      idx       <= '0;
      carry     <= 1'b0;
      carry_out <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_n == ST_IDLE);
      out_valid <= (state_n == ST_DONE);
      if (accept_c) begin
        // Subtract is a + ~b + 1: invert b once here, seed the carry with 1.
        a_q   <= a;
        b_q   <= sub_c ? ~b : b;
        carry <= sub_c;
        idx   <= '0;
      end else if (run_c) begin
        sum_q[idx] <= inc_c[WIDTH-1:0];
        carry      <= kc_c | inc_c[WIDTH];
        if (last_c) carry_out <= kc_c | inc_c[WIDTH];
        else        idx       <= idx + IDXW'(1);
      end
    end
  end

  assign sum = sum_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed bench for multiword_add_sequencer at WIDTH=8, WORDS=4 (subtract cases with MULTIWORD_SUB_EN).
module tb_multiword_add_sequencer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned WORDS = 4;
  localparam int          LAT   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        carry_out;

  int tests = 0;
  int fails = 0;

  multiword_add_sequencer #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef MULTIWORD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // One complete transaction; returns result and cycles from accept to out_valid.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic sb,
                        input int stall, output logic [31:0] s, output logic c, output int lat);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    a = av;
    b = bv;
    sub = sb;
`ifndef MULTIWORD_SUB_EN
    if (sb) $display("note: subtract requested but not built in");
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    sub = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    repeat (stall) begin
      @(posedge clk); #1;
    end
    s = sum;
    c = carry_out;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    sub = 1'b0;
    #23;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 32'h0 || carry_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b sum=%h carry_out=%b, want 1 0 00000000 0",
               in_ready, out_valid, sum, carry_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_vectors();
    logic [31:0] va [6] = '{32'h00000001, 32'h000000FF, 32'hFFFFFFFF,
                            32'h80000000, 32'h12345678, 32'h00FF00FF};
    logic [31:0] vb [6] = '{32'h00000002, 32'h00000001, 32'h00000001,
                            32'h80000000, 32'h11111111, 32'h00010001};
    logic [31:0] es [6] = '{32'h00000003, 32'h00000100, 32'h00000000,
                            32'h00000000, 32'h23456789, 32'h01000100};
    logic        ec [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] s;
    logic        c;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], 1'b0, 0, s, c, lat);
      tests++;
      if (lat != LAT) begin
        fails++;
        $display("FAIL add_latency[%0d]: got %0d cycles, want %0d", i, lat, LAT);
      end
      tests++;
      if (s !== es[i] || c !== ec[i]) begin
        fails++;
        $display("FAIL add_result[%0d]: sum=%h carry_out=%b, want %h %b", i, s, c, es[i], ec[i]);
      end
    end
  endtask

  // Result held across a long stall; a pending request is only accepted in the following IDLE cycle.
  task automatic test_stall();
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    a = 32'h01020304;
    b = 32'h10203040;
    @(posedge clk); #1;
    a = 32'hFFFFFFFF;
    b = 32'h00000001;
    repeat (LAT) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 32'h11223344 || carry_out !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold[%0d]: out_valid=%b in_ready=%b sum=%h carry_out=%b, want 1 0 11223344 0",
                 i, out_valid, in_ready, sum, carry_out);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL stall_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL next_accept: in_ready=%b after idle cycle with in_valid, want 0", in_ready);
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    tests++;
    if (lat != LAT || sum !== 32'h00000000 || carry_out !== 1'b1) begin
      fails++;
      $display("FAIL queued_op: lat=%0d sum=%h carry_out=%b, want %0d 00000000 1", lat, sum, carry_out, LAT);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] s;
    logic        c;
    int          lat;
    @(negedge clk);
    in_valid = 1'b1;
    a = 32'h11223344;
    b = 32'h01010101;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    tests++;
    if (sum !== 32'h00003445 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL partial_run: sum=%h in_ready=%b out_valid=%b, want 00003445 0 0", sum, in_ready, out_valid);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 32'h0 || carry_out !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: in_ready=%b out_valid=%b sum=%h carry_out=%b, want 1 0 00000000 0",
               in_ready, out_valid, sum, carry_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(32'h00000005, 32'h00000006, 1'b0, 0, s, c, lat);
    tests++;
    if (lat != LAT || s !== 32'h0000000B || c !== 1'b0) begin
      fails++;
      $display("FAIL after_reset: lat=%0d sum=%h carry_out=%b, want %0d 0000000b 0", lat, s, c, LAT);
    end
  endtask

`ifdef MULTIWORD_SUB_EN
  task automatic test_sub();
    logic [31:0] s;
    logic        c;
    int          lat;
    run_op(32'h00000005, 32'h00000007, 1'b1, 0, s, c, lat);
    tests++;
    if (s !== 32'hFFFFFFFE || c !== 1'b0) begin
      fails++;
      $display("FAIL sub_borrow: sum=%h carry_out=%b, want fffffffe 0", s, c);
    end
    run_op(32'h00000007, 32'h00000005, 1'b1, 1, s, c, lat);
    tests++;
    if (s !== 32'h00000002 || c !== 1'b1) begin
      fails++;
      $display("FAIL sub_no_borrow: sum=%h carry_out=%b, want 00000002 1", s, c);
    end
  endtask
`endif

  task automatic test_random();
    logic [31:0] av, bv, s;
    logic        c, sb;
    logic [32:0] ref_sum;
    int          lat;
    for (int i = 0; i < 300; i++) begin
      av = $urandom;
      bv = $urandom;
      if (i % 7 == 0) av = 32'hFFFFFFFF;
`ifdef MULTIWORD_SUB_EN
      sb = 1'($urandom_range(1, 0));
`else
      sb = 1'b0;
`endif
      ref_sum = sb ? ({1'b0, av} + {1'b0, ~bv} + 33'd1) : ({1'b0, av} + {1'b0, bv});
      run_op(av, bv, sb, int'($urandom_range(3, 0)), s, c, lat);
      tests++;
      if (s !== ref_sum[31:0] || c !== ref_sum[32] || lat != LAT) begin
        fails++;
        $display("FAIL random[%0d]: a=%h b=%h sub=%b got sum=%h c=%b lat=%0d, want %h %b %0d",
                 i, av, bv, sb, s, c, lat, ref_sum[31:0], ref_sum[32], LAT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_vectors();
    test_stall();
    test_reset_mid_run();
`ifdef MULTIWORD_SUB_EN
    test_sub();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
